// File: rtl/ocx_req_sched.sv
// ---------------------------------------------------------------------------
// ocx_req_sched
//
// Shares the single OpenCAPI request channel among the per-stream L2 refill
// requesters. One stream is granted per cycle in round-robin order. A grant
// is only allowed when the stream and the block as a whole are below their
// outstanding-request caps. The winning stream id is registered onto the
// OpenCAPI request interface. OpenCAPI responses are steered combinationally
// back to the owning stream, and each accepted response returns one credit.
//
// Parameters
//   nstrms        number of streams (>= 2)
//   nstrms_width  stream id width
//   max_out       global cap on outstanding requests (1..255)
//   strm_max      per-stream cap on outstanding requests (1..max_out)
//
// Ports
//   clk, reset    single clock, synchronous active-high reset
//   i_req_v/r     per-stream request valid / one-hot grant (combinational)
//   o_req_v/r     OpenCAPI request valid (registered) / ready
//   o_req_sid     stream id of the registered request
//   i_rsp_v/r     OpenCAPI response valid / ready (combinational)
//   i_rsp_sid     stream id carried by the response
//   o_rsp_v/r     per-stream response valid (one-hot) / per-stream ready
//   o_err         sticky flag: response arrived for a stream with no credit out
// ---------------------------------------------------------------------------
module ocx_req_sched #(
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int max_out      = 32,
    parameter int strm_max     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [nstrms-1:0]       i_req_v,
    output logic [nstrms-1:0]       i_req_r,
    output logic                    o_req_v,
    input  logic                    o_req_r,
    output logic [nstrms_width-1:0] o_req_sid,
    input  logic                    i_rsp_v,
    output logic                    i_rsp_r,
    input  logic [nstrms_width-1:0] i_rsp_sid,
    output logic [nstrms-1:0]       o_rsp_v,
    input  logic [nstrms-1:0]       o_rsp_r,
    output logic                    o_err
);

    localparam int GCNT_W = $clog2(max_out + 1);
    localparam int SCNT_W = $clog2(strm_max + 1);

    localparam logic [GCNT_W-1:0]       GCNT_MAX = GCNT_W'(max_out);
    localparam logic [SCNT_W-1:0]       SCNT_MAX = SCNT_W'(strm_max);
    localparam logic [nstrms_width-1:0] SID_LAST = nstrms_width'(nstrms - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [GCNT_W-1:0]       r_gcnt;
    logic [SCNT_W-1:0]       r_scnt [nstrms];
    logic [nstrms_width-1:0] r_rr;
    logic                    r_req_v;
    logic [nstrms_width-1:0] r_req_sid;
    logic                    r_err;

    // -----------------------------------------------------------------------
    // Combinational nets
    // -----------------------------------------------------------------------
    logic                    w_slot_free;
    logic                    w_gate;
    logic [nstrms-1:0]       w_elig;
    logic [nstrms-1:0]       w_hi_mask;
    logic [nstrms-1:0]       w_hi_elig;
    logic [nstrms-1:0]       w_pick_vec;
    logic [nstrms-1:0]       w_has_cred;
    logic [nstrms-1:0]       w_fire;
    logic                    w_grant;
    logic [nstrms_width-1:0] w_gsid;
    logic                    w_dec;
    logic                    w_bad_rsp;

    // The output register can take a new request when it is empty or when
    // its current contents are being consumed this cycle.
    assign w_slot_free = !r_req_v || o_req_r;

    // Conditions shared by every stream. Reset blocks all grants.
    assign w_gate = !reset && w_slot_free && (r_gcnt < GCNT_MAX);

    generate
        for (genvar gi = 0; gi < nstrms; gi++) begin : g_strm
            assign w_has_cred[gi] = (r_scnt[gi] != '0);
            assign w_elig[gi]     = w_gate && i_req_v[gi] && (r_scnt[gi] < SCNT_MAX);

            // Streams at or above the round-robin pointer get first pick.
            assign w_hi_mask[gi]  = (nstrms_width'(gi) >= r_rr);

            assign i_req_r[gi]    = w_grant && (w_gsid == nstrms_width'(gi));

            // Response steering; an out-of-range sid simply selects nobody.
            assign o_rsp_v[gi]    = !reset && i_rsp_v && (i_rsp_sid == nstrms_width'(gi));
            assign w_fire[gi]     = o_rsp_v[gi] && o_rsp_r[gi];
        end
    endgenerate

    // Round-robin pick: lowest eligible index at or above rr, otherwise the
    // lowest eligible index overall (the wrap-around part of the scan).
    assign w_hi_elig  = w_elig & w_hi_mask;
    assign w_pick_vec = (|w_hi_elig) ? w_hi_elig : w_elig;
    assign w_grant    = |w_elig;

    always_comb begin
        w_gsid = '0;
        for (int k = nstrms - 1; k >= 0; k--) begin
            if (w_pick_vec[k]) begin
                w_gsid = nstrms_width'(k);
            end
        end
    end

    // At most one bit of w_fire can be set, so the OR reductions below are
    // the state of the single addressed stream.
    assign i_rsp_r   = |w_fire;
    assign w_dec     = |(w_fire & w_has_cred);
    assign w_bad_rsp = |(w_fire & ~w_has_cred);

    // -----------------------------------------------------------------------
    // Per-stream outstanding counters. A grant and a credit-returning
    // response on the same stream cancel out.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < nstrms; k++) begin
                r_scnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < nstrms; k++) begin
                case ({i_req_r[k], w_fire[k] && w_has_cred[k]})
                    2'b10:   r_scnt[k] <= r_scnt[k] + SCNT_W'(1);
                    2'b01:   r_scnt[k] <= r_scnt[k] - SCNT_W'(1);
                    default: r_scnt[k] <= r_scnt[k];
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Global outstanding counter, request output register, rr pointer and
    // the sticky error flag.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gcnt    <= '0;
            r_rr      <= '0;
            r_req_v   <= 1'b0;
            r_req_sid <= '0;
            r_err     <= 1'b0;
        end else begin
            case ({w_grant, w_dec})
                2'b10:   r_gcnt <= r_gcnt + GCNT_W'(1);
                2'b01:   r_gcnt <= r_gcnt - GCNT_W'(1);
                default: r_gcnt <= r_gcnt;
            endcase

            if (w_grant) begin
                r_req_v   <= 1'b1;
                r_req_sid <= w_gsid;
                r_rr      <= (w_gsid == SID_LAST) ? '0 : w_gsid + nstrms_width'(1);
            end else if (o_req_r) begin
                r_req_v   <= 1'b0;
            end

            if (w_bad_rsp) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_req_v   = r_req_v;
    assign o_req_sid = r_req_sid;
    assign o_err     = r_err;

endmodule
